// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: D-stage decode fields, forwarded operands and pipeline control outputs
interface pipe_hazard_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [5:0]        fd_opcode;
    logic [5:0]        fd_funct;
    logic [REG_AW-1:0] fd_rs;
    logic [REG_AW-1:0] fd_rt;
    logic [REG_AW-1:0] fd_rd;
    logic [DATA_W-1:0] fwd_rd_data1;
    logic [DATA_W-1:0] fwd_rd_data2;
    logic              pc_stall;
    logic              dx_bubble;
    logic              fd_flush;
    logic [1:0]        d_pc_sel;
    logic [3:0]        x_alu_ctrl;
    logic              m_MemRead;
    logic              m_MemWrite;
    logic              w_MemtoReg;
    logic              mw_RegWrite;
    logic [REG_AW-1:0] mw_wr_addr;
    logic              mdu_busy;

    modport master (
        output fd_opcode, fd_funct, fd_rs, fd_rt, fd_rd, fwd_rd_data1, fwd_rd_data2,
        input  pc_stall, dx_bubble, fd_flush, d_pc_sel, x_alu_ctrl, m_MemRead, m_MemWrite,
               w_MemtoReg, mw_RegWrite, mw_wr_addr, mdu_busy
    );

    modport slave (
        input  fd_opcode, fd_funct, fd_rs, fd_rt, fd_rd, fwd_rd_data1, fwd_rd_data2,
        output pc_stall, dx_bubble, fd_flush, d_pc_sel, x_alu_ctrl, m_MemRead, m_MemWrite,
               w_MemtoReg, mw_RegWrite, mw_wr_addr, mdu_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage MIPS control with load-use/branch/MDU hazards and D-stage branch resolution
// PIPE_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int TD      = 1
) (
    input  logic clock,
    input  logic reset,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    if (TD < 0 || MDU_LAT < 1 || MDU_LAT > 15) begin : g_illegal_params
    end

    logic [5:0]        dx_opcode, dx_funct, xm_opcode, mw_opcode;
    logic [3:0]        dx_alu, mdu_cnt, d_alu;
    logic              dx_reg_write, xm_reg_write, mw_reg_write;
    logic [REG_AW-1:0] dx_wr_addr, xm_wr_addr, mw_wr_addr, d_dest;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic is_r, is_j, is_jal, is_beq, is_bne, is_load, is_store, is_lui;
    logic is_jr, is_mdu, is_mf, is_shift_imm, use_rs, use_rt, d_reg_write;
    logic dx_hit, xm_hit, dx_load, xm_load, dx_mdu;
    logic load_use, br_haz, mdu_stall, pc_stall, taken, fd_flush;

    assign rs_val       = bus.fwd_rd_data1;
    assign rt_val       = bus.fwd_rd_data2;
    assign is_r         = bus.fd_opcode == OP_R;
    assign is_j         = bus.fd_opcode == OP_J;
    assign is_jal       = bus.fd_opcode == OP_JAL;
    assign is_beq       = bus.fd_opcode == OP_BEQ;
    assign is_bne       = bus.fd_opcode == OP_BNE;
    assign is_lui       = bus.fd_opcode == OP_LUI;
    assign is_load      = bus.fd_opcode[5:3] == 3'b100;
    assign is_store     = bus.fd_opcode[5:3] == 3'b101;
    assign is_jr        = is_r && bus.fd_funct == FN_JR;
    assign is_mdu       = is_r && (bus.fd_funct == FN_MULT || bus.fd_funct == FN_DIV);
    assign is_mf        = is_r && (bus.fd_funct == FN_MFHI || bus.fd_funct == FN_MFLO);
    assign is_shift_imm = is_r && (bus.fd_funct == FN_SLL || bus.fd_funct == FN_SRL || bus.fd_funct == FN_SRA);

    // rt is only a source for R-type, branches and stores; elsewhere it names the destination
    assign use_rs      = !(is_j || is_jal || is_lui || is_mf || is_shift_imm);
    assign use_rt      = (is_r && !is_jr && !is_mf) || is_beq || is_bne || is_store;
    assign d_dest      = is_jal ? '1 : is_r ? bus.fd_rd : bus.fd_rt;
    assign d_reg_write = !(is_store || is_beq || is_bne || is_j || is_jr || is_mdu) && d_dest != '0;

    always_comb begin
        d_alu = 4'd0;
        if (is_r) begin
            case (bus.fd_funct)
                FN_ADD:  d_alu = 4'd0;
                FN_AND:  d_alu = 4'd1;
                FN_OR:   d_alu = 4'd2;
                FN_SLL:  d_alu = 4'd3;
                FN_SLT:  d_alu = 4'd4;
                FN_SRL:  d_alu = 4'd5;
                FN_SUB:  d_alu = 4'd6;
                FN_XOR:  d_alu = 4'd7;
                FN_SRA:  d_alu = 4'd8;
                FN_NOR:  d_alu = 4'd9;
                default: d_alu = 4'd0;
            endcase
        end else begin
            case (bus.fd_opcode)
                OP_ANDI: d_alu = 4'd1;
                OP_ORI:  d_alu = 4'd2;
                OP_SLTI: d_alu = 4'd4;
                OP_XORI: d_alu = 4'd7;
                OP_LUI:  d_alu = 4'd10;
                default: d_alu = 4'd0;
            endcase
        end
    end

    assign dx_hit  = dx_reg_write && ((use_rs && dx_wr_addr == bus.fd_rs) || (use_rt && dx_wr_addr == bus.fd_rt));
    assign xm_hit  = xm_reg_write && ((use_rs && xm_wr_addr == bus.fd_rs) || (use_rt && xm_wr_addr == bus.fd_rt));
    assign dx_load = dx_opcode[5:3] == 3'b100;
    assign xm_load = xm_opcode[5:3] == 3'b100;
    assign dx_mdu  = dx_opcode == OP_R && (dx_funct == FN_MULT || dx_funct == FN_DIV);

    // a load in DX feeding a branch stalls here, then again via the XM check next cycle
    assign load_use  = dx_hit && dx_load;
    assign br_haz    = (is_beq || is_bne || is_jr) && (dx_hit || (xm_hit && xm_load));
    assign mdu_stall = mdu_cnt != 4'd0 && (is_mf || is_mdu);
    assign pc_stall  = load_use || br_haz || mdu_stall;
    assign taken     = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);
    assign fd_flush  = !pc_stall && (taken || is_j || is_jal || is_jr);

    assign bus.pc_stall    = pc_stall;
    assign bus.dx_bubble   = pc_stall;
    assign bus.fd_flush    = fd_flush;
    assign bus.d_pc_sel    = pc_stall ? 2'd0 : taken ? 2'd1 : (is_j || is_jal) ? 2'd2 : is_jr ? 2'd3 : 2'd0;
    assign bus.x_alu_ctrl  = dx_alu;
    assign bus.m_MemRead   = xm_load;
    assign bus.m_MemWrite  = xm_opcode[5:3] == 3'b101;
    assign bus.w_MemtoReg  = mw_opcode[5:3] == 3'b100;
    assign bus.mw_RegWrite = mw_reg_write;
    assign bus.mw_wr_addr  = mw_wr_addr;
    assign bus.mdu_busy    = mdu_cnt != 4'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            dx_opcode    <= '0;
            dx_funct     <= '0;
            dx_alu       <= '0;
            dx_reg_write <= 1'b0;
            dx_wr_addr   <= '0;
            xm_opcode    <= '0;
            xm_reg_write <= 1'b0;
            xm_wr_addr   <= '0;
            mw_opcode    <= '0;
            mw_reg_write <= 1'b0;
            mw_wr_addr   <= '0;
            mdu_cnt      <= '0;
        end else begin
            dx_opcode    <= pc_stall ? '0 : bus.fd_opcode;
            dx_funct     <= pc_stall ? '0 : bus.fd_funct;
            dx_alu       <= pc_stall ? '0 : d_alu;
            dx_reg_write <= pc_stall ? 1'b0 : d_reg_write;
            dx_wr_addr   <= pc_stall ? '0 : d_dest;
            xm_opcode    <= dx_opcode;
            xm_reg_write <= dx_reg_write;
            xm_wr_addr   <= dx_wr_addr;
            mw_opcode    <= xm_opcode;
            mw_reg_write <= xm_reg_write;
            mw_wr_addr   <= xm_wr_addr;
            mdu_cnt      <= dx_mdu ? 4'(MDU_LAT) : mdu_cnt - 4'(mdu_cnt != 4'd0);
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
            if (fd_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queued scoreboard and a negedge monitor
module tb_pipe_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;
    logic [18:0] exp_q[$];
    string name_q[$];

    localparam int LW = 'h23, SW = 'h2B, BEQ = 4, BNE = 5, JAL = 3, ADDI = 'h08;
    localparam int ANDI = 'h0C, ORI = 'h0D, SLTI = 'h0A, LUI = 'h0F;
    localparam int ADD = 'h20, SUB = 'h22, SRA = 3, SRL = 2, NOR = 'h27, XOR = 'h26;
    localparam int JR = 8, MULT = 'h18, DIV = 'h1A, MFLO = 'h12;
    localparam logic [26:0] NOP = '0;

    pipe_hazard_ctrl_if #(.DATA_W(32), .REG_AW(5)) bus ();
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl dut (
        .clock(clock),
        .reset(reset),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
`endif
        .bus(bus)
    );

    always #5 clock = ~clock;

    function automatic logic [26:0] ri(int fn, int rs, int rt, int rd);
        return {6'd0, 6'(fn), 5'(rs), 5'(rt), 5'(rd)};
    endfunction

    function automatic logic [26:0] ii(int op, int rs, int rt);
        return {6'(op), 6'd0, 5'(rs), 5'(rt), 5'd0};
    endfunction

    // {stall, bubble, flush, pc_sel, alu, MemRead, MemWrite, MemtoReg, RegWrite, wr_addr, busy}
    function automatic logic [18:0] e(int s, int b, int f, int sel, int alu, int mr, int mw,
                                      int m2r, int rw, int wa, int busy);
        return {1'(s), 1'(b), 1'(f), 2'(sel), 4'(alu), 1'(mr), 1'(mw), 1'(m2r), 1'(rw), 5'(wa), 1'(busy)};
    endfunction

    task automatic step(input string n, input logic r, input logic [26:0] ins,
                        input logic [31:0] a, input logic [31:0] b, input logic [18:0] x);
        @(posedge clock);
        #1;
        reset = r;
        {bus.fd_opcode, bus.fd_funct, bus.fd_rs, bus.fd_rt, bus.fd_rd} = ins;
        bus.fwd_rd_data1 = a;
        bus.fwd_rd_data2 = b;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    initial begin
        logic [18:0] act, want;
        string n;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                n = name_q.pop_front();
                act = {bus.pc_stall, bus.dx_bubble, bus.fd_flush, bus.d_pc_sel, bus.x_alu_ctrl,
                       bus.m_MemRead, bus.m_MemWrite, bus.w_MemtoReg, bus.mw_RegWrite,
                       bus.mw_wr_addr, bus.mdu_busy};
                compared++;
                if (act !== want) begin
                    mismatched++;
                    $display("FAIL %s: got %b required %b", n, act, want);
                end
            end
        end
    end

    initial begin
        {bus.fd_opcode, bus.fd_funct, bus.fd_rs, bus.fd_rt, bus.fd_rd} = NOP;
        bus.fwd_rd_data1 = '0;
        bus.fwd_rd_data2 = '0;
        repeat (2) @(posedge clock);
        step("reset",        1, NOP,               0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("lw_r2",        0, ii(LW,1,2),        0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("load_use",     0, ri(ADD,2,4,3),     0, 0, e(1,1,0,0,0,0,0,0,0,0,0));
        step("lu_release",   0, ri(ADD,2,4,3),     0, 0, e(0,0,0,0,0,1,0,0,0,0,0));
        step("add_in_x",     0, NOP,               0, 0, e(0,0,0,0,0,0,0,1,1,2,0));
        step("sub_d",        0, ri(SUB,9,10,8),    0, 0, e(0,0,0,0,3,0,0,0,0,0,0));
        step("sra_d",        0, ri(SRA,0,2,4),     0, 0, e(0,0,0,0,6,0,0,0,1,3,0));
        step("nor_d",        0, ri(NOR,12,13,11),  0, 0, e(0,0,0,0,8,0,0,0,0,0,0));
        step("lui_d",        0, ii(LUI,0,6),       0, 0, e(0,0,0,0,9,0,0,0,1,8,0));
        step("sw_d",         0, ii(SW,1,6),        0, 0, e(0,0,0,0,10,0,0,0,1,4,0));
        step("sw_in_x",      0, NOP,               0, 0, e(0,0,0,0,0,0,0,0,1,11,0));
        step("sw_in_m",      0, NOP,               0, 0, e(0,0,0,0,3,0,1,0,1,6,0));
        step("beq_taken",    0, ii(BEQ,1,1),       5, 5, e(0,0,1,1,3,0,0,0,0,6,0));
        step("beq_not",      0, ii(BEQ,1,1),       5, 6, e(0,0,0,0,0,0,0,0,0,0,0));
        step("lw_r7",        0, ii(LW,0,7),        0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("bne_ld_dx",    0, ii(BNE,7,0),       3, 0, e(1,1,0,0,0,0,0,0,0,1,0));
        step("bne_ld_xm",    0, ii(BNE,7,0),       3, 0, e(1,1,0,0,0,1,0,0,0,1,0));
        step("bne_taken",    0, ii(BNE,7,0),       3, 0, e(0,0,1,1,0,0,0,1,1,7,0));
        step("add_r9",       0, ri(ADD,1,2,9),     0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("jr_dx_haz",    0, ri(JR,9,0,0),      0, 0, e(1,1,0,0,0,0,0,0,0,0,0));
        step("jr",           0, ri(JR,9,0,0),      0, 0, e(0,0,1,3,0,0,0,0,0,0,0));
        step("jal",          0, ii(JAL,0,0),       0, 0, e(0,0,1,2,0,0,0,0,1,9,0));
        step("add_r0",       0, ri(ADD,1,2,0),     0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("jr_in_wb",     0, NOP,               0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("jal_wb",       0, NOP,               0, 0, e(0,0,0,0,3,0,0,0,1,31,0));
        step("add_r0_wb",    0, ri(MULT,1,2,0),    0, 0, e(0,0,0,0,3,0,0,0,0,0,0));
        step("mult_in_x",    0, NOP,               0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("mflo_busy1",   0, ri(MFLO,0,0,5),    0, 0, e(1,1,0,0,3,0,0,0,0,0,1));
        step("mflo_busy2",   0, ri(MFLO,0,0,5),    0, 0, e(1,1,0,0,0,0,0,0,0,0,1));
        step("mflo_busy3",   0, ri(MFLO,0,0,5),    0, 0, e(1,1,0,0,0,0,0,0,0,0,1));
        step("mflo_busy4",   0, ri(MFLO,0,0,5),    0, 0, e(1,1,0,0,0,0,0,0,0,0,1));
        step("mflo_go",      0, ri(MFLO,0,0,5),    0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("mult2",        0, ri(MULT,1,2,0),    0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("div_idle",     0, ri(DIV,3,4,0),     0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("mult_busy",    0, ri(MULT,1,2,0),    0, 0, e(1,1,0,0,0,0,0,0,1,5,1));
        step("reset_busy",   1, NOP,               0, 0, e(0,0,0,0,0,0,0,0,0,0,1));
        step("after_reset",  0, NOP,               0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("andi_d",       0, ii(ANDI,0,1),      0, 0, e(0,0,0,0,3,0,0,0,0,0,0));
        step("ori_d",        0, ii(ORI,0,2),       0, 0, e(0,0,0,0,1,0,0,0,0,0,0));
        step("slti_d",       0, ii(SLTI,0,3),      0, 0, e(0,0,0,0,2,0,0,0,0,0,0));
        step("srl_d",        0, ri(SRL,0,0,4),     0, 0, e(0,0,0,0,4,0,0,0,1,1,0));
        step("xor_d",        0, ri(XOR,0,0,5),     0, 0, e(0,0,0,0,5,0,0,0,1,2,0));
        step("xor_in_x",     0, NOP,               0, 0, e(0,0,0,0,7,0,0,0,1,3,0));
        step("srl_wb",       0, NOP,               0, 0, e(0,0,0,0,3,0,0,0,1,4,0));
        step("lw_r8",        0, ii(LW,0,8),        0, 0, e(0,0,0,0,3,0,0,0,1,5,0));
        step("addi_rt_dest", 0, ii(ADDI,0,8),      0, 0, e(0,0,0,0,0,0,0,0,0,0,0));
        step("sw_no_stall",  0, ii(SW,0,8),        0, 0, e(0,0,0,0,0,1,0,0,0,0,0));
        step("lw_r8_wb",     0, NOP,               0, 0, e(0,0,0,0,0,0,0,1,1,8,0));
        repeat (2) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
